link_input_buffer: RTL and testbench

Receive-side flit buffer at the input of each router port. It sits directly downstream of the neighbouring router's output unit and consumes that unit's flit and downstream-request outputs. It returns a one-cycle acknowledge, checks the head/body/tail packet sequence, stores flits in a FIFO and presents them with first-word fall-through to the local route-compute stage.

---
 rtl/link_input_buffer.sv | 120 ++++++++++++
 tb/tb_link_input_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/link_input_buffer.sv
// Receive-side flit buffer for one router input port: one-cycle ack handshake,
// head/body/tail sequence checking, and a first-word fall-through FIFO.
module link_input_buffer #(
    parameter int FLIT_W = 34,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [FLIT_W-1:0]          i_flit,
    input  logic                       i_upstream_req,
    output logic                       o_upstream_ack,
    output logic [FLIT_W-1:0]          o_flit,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_err_seq,
    output logic                       o_err_type
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {S_IDLE = 1'b0, S_IN_PKT = 1'b1} state_t;

    logic [FLIT_W-1:0] r_mem [0:DEPTH-1];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    state_t            r_state;
    logic              r_ack;
    logic              r_err_seq;
    logic              r_err_type;

    logic [1:0]        w_type;
    logic              w_accept;
    logic              w_pop;
    logic              w_write;
    logic              w_drop_seq;
    logic              w_drop_type;
    state_t            w_next_state;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_flit  = o_valid ? r_mem[r_rd_ptr] : '0;

    assign o_upstream_ack = r_ack;
    assign o_err_seq      = r_err_seq;
    assign o_err_type     = r_err_type;

    // A held request is blocked during its own ack cycle so it is never taken twice.
    assign w_type   = i_flit[FLIT_W-1 -: 2];
    assign w_accept = i_upstream_req && !o_full && !r_ack;
    assign w_pop    = o_valid && i_ready;

    always_comb begin
        w_write      = 1'b0;
        w_drop_seq   = 1'b0;
        w_drop_type  = 1'b0;
        w_next_state = r_state;
        if (w_accept) begin
            case (w_type)
                2'b01: begin
                    if (r_state == S_IDLE) begin
                        w_write      = 1'b1;
                        w_next_state = S_IN_PKT;
                    end else begin
                        w_drop_seq = 1'b1;
                    end
                end
                2'b10: begin
                    if (r_state == S_IN_PKT) w_write = 1'b1;
                    else                     w_drop_seq = 1'b1;
                end
                2'b11: begin
                    if (r_state == S_IN_PKT) begin
                        w_write      = 1'b1;
                        w_next_state = S_IDLE;
                    end else begin
                        w_drop_seq = 1'b1;
                    end
                end
                default: w_drop_type = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ack      <= 1'b0;
            r_err_seq  <= 1'b0;
            r_err_type <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_ack      <= w_accept;
            r_err_seq  <= w_drop_seq;
            r_err_type <= w_drop_type;
            if (w_write) begin
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observable once counted in.
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_wr_ptr] <= i_flit;
    end
endmodule

// File: tb/tb_link_input_buffer.sv
// Bench for link_input_buffer: directed protocol scenarios plus random traffic,
// every cycle compared against a queue-based packet/FIFO reference model.
module tb_link_input_buffer;
  localparam int FLIT_W = 34;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [FLIT_W-1:0] i_flit = '0;
  logic              i_upstream_req = 1'b0;
  logic              o_upstream_ack;
  logic [FLIT_W-1:0] o_flit;
  logic              o_valid;
  logic              i_ready = 1'b0;
  logic [CW-1:0]     o_count;
  logic              o_full;
  logic              o_err_seq;
  logic              o_err_type;

  int n_cmp = 0;
  int n_fail = 0;
  bit rand_ready = 1'b0;

  link_input_buffer #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .i_flit(i_flit), .i_upstream_req(i_upstream_req),
    .o_upstream_ack(o_upstream_ack), .o_flit(o_flit), .o_valid(o_valid), .i_ready(i_ready),
    .o_count(o_count), .o_full(o_full), .o_err_seq(o_err_seq), .o_err_type(o_err_type)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: packet legality decided per flit, storage as a plain queue
  logic [FLIT_W-1:0] exp_q[$];
  bit m_in_pkt = 1'b0;
  bit m_ack = 1'b0;
  bit m_es = 1'b0;
  bit m_et = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_ack = 1'b0;
      m_es = 1'b0;
      m_et = 1'b0;
    end else begin
      bit acc;
      bit es;
      bit et;
      logic [1:0] t;
      acc = i_upstream_req && (exp_q.size() != DEPTH) && !m_ack;
      es = 1'b0;
      et = 1'b0;
      if (exp_q.size() != 0 && i_ready) void'(exp_q.pop_front());
      if (acc) begin
        t = i_flit[FLIT_W-1 -: 2];
        if (t == 2'b00) et = 1'b1;
        else if (!m_in_pkt) begin
          if (t == 2'b01) begin exp_q.push_back(i_flit); m_in_pkt = 1'b1; end
          else es = 1'b1;
        end else begin
          if (t == 2'b01) es = 1'b1;
          else begin
            exp_q.push_back(i_flit);
            if (t == 2'b11) m_in_pkt = 1'b0;
          end
        end
      end
      m_ack = acc;
      m_es = es;
      m_et = et;
    end
  end

  // scoreboard: compare every output on the falling edge
  always @(negedge clk) begin
    check("ack", 64'(o_upstream_ack), 64'(m_ack));
    check("err_seq", 64'(o_err_seq), 64'(m_es));
    check("err_type", 64'(o_err_type), 64'(m_et));
    check("count", 64'(o_count), 64'(exp_q.size()));
    check("valid", 64'(o_valid), 64'(exp_q.size() != 0));
    check("full", 64'(o_full), 64'(exp_q.size() == DEPTH));
    check("flit", 64'(o_flit), (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] p, output logic es, output logic et);
    bit got;
    got = 1'b0;
    es = 1'b0;
    et = 1'b0;
    i_flit = {t, p};
    i_upstream_req = 1'b1;
    for (int c = 0; c < 60 && !got; c++) begin
      step();
      if (o_upstream_ack) begin
        got = 1'b1;
        es = o_err_seq;
        et = o_err_type;
      end
    end
    i_upstream_req = 1'b0;
    if (!got) check("ack_timeout", 64'(got), 64'd1);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int c = 0; c < 40 && o_valid; c++) step();
    i_ready = 1'b0;
    check("drained", 64'(o_valid), 64'd0);
  endtask

  initial begin
    logic es;
    logic et;
    logic [1:0] t;
    int r;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_flit", 64'(o_flit), 64'd0);
    check("rst_ack", 64'(o_upstream_ack), 64'd0);
    reset_n = 1'b1;
    step();

    // head/body/tail with consumer stalled
    send(2'b01, 32'h1, es, et); check("hbt_cnt1", 64'(o_count), 64'd1);
    send(2'b10, 32'h2, es, et); check("hbt_cnt2", 64'(o_count), 64'd2);
    send(2'b11, 32'h3, es, et); check("hbt_cnt3", 64'(o_count), 64'd3);
    check("hbt_head", 64'(o_flit), {30'd0, 2'b01, 32'h1});
    send(2'b10, 32'h4, es, et); check("hbt_idle", 64'(es), 64'd1);
    drain();

    // fill to DEPTH, then hold a fifth request against a full buffer
    send(2'b01, 32'h10, es, et);
    for (int k = 1; k <= 3; k++) send(2'b10, 32'h10 + 32'(k), es, et);
    check("full_cnt", 64'(o_count), 64'd4);
    check("full_flag", 64'(o_full), 64'd1);
    i_flit = {2'b10, 32'h14};
    i_upstream_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("held_no_ack", 64'(o_upstream_ack), 64'd0);
    end
    i_ready = 1'b1;
    step();
    i_ready = 1'b0;
    r = 0;
    while (!o_upstream_ack && r < 10) begin step(); r++; end
    i_upstream_req = 1'b0;
    check("held_acked", 64'(o_upstream_ack), 64'd1);
    check("held_cnt", 64'(o_count), 64'd4);
    drain();
    send(2'b11, 32'h15, es, et);
    drain();

    // sequence and type errors
    send(2'b10, 32'h20, es, et); check("seq_body", 64'(es), 64'd1);
    send(2'b11, 32'h21, es, et); check("seq_tail", 64'(es), 64'd1);
    check("seq_cnt0", 64'(o_count), 64'd0);
    check("seq_valid0", 64'(o_valid), 64'd0);
    send(2'b01, 32'h22, es, et); check("seq_head_ok", 64'(es), 64'd0);
    send(2'b01, 32'h23, es, et); check("seq_head2", 64'(es), 64'd1);
    send(2'b00, 32'h24, es, et); check("type_err", 64'(et), 64'd1);
    check("type_cnt", 64'(o_count), 64'd1);
    send(2'b11, 32'h25, es, et); check("type_tail_ok", 64'(es), 64'd0);
    check("type_cnt2", 64'(o_count), 64'd2);
    drain();

    // streaming across pointer wrap with the consumer always ready
    send(2'b01, 32'h30, es, et);
    send(2'b10, 32'h31, es, et);
    send(2'b10, 32'h32, es, et);
    i_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send((k == 7) ? 2'b11 : 2'b10, 32'h33 + 32'(k), es, et);
      check("stream_le2", 64'(o_count <= CW'(2)), 64'd1);
    end
    i_ready = 1'b0;

    // reset in the middle of a packet
    send(2'b01, 32'h40, es, et);
    i_flit = {2'b10, 32'h41};
    i_upstream_req = 1'b1;
    step();
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ack", 64'(o_upstream_ack), 64'd0);
    check("mid_rst_valid", 64'(o_valid), 64'd0);
    check("mid_rst_cnt", 64'(o_count), 64'd0);
    check("mid_rst_flit", 64'(o_flit), 64'd0);
    i_upstream_req = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    send(2'b01, 32'h50, es, et);
    check("post_rst_cnt", 64'(o_count), 64'd1);
    check("post_rst_flit", 64'(o_flit), {30'd0, 2'b01, 32'h50});
    drain();

    // random traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      r = $urandom_range(0, 19);
      if (r == 0) t = 2'b00;
      else if (r < 6) t = 2'b01;
      else if (r < 15) t = 2'b10;
      else t = 2'b11;
      send(t, $urandom, es, et);
      repeat ($urandom_range(0, 2)) step();
    end
    rand_ready = 1'b0;
    i_ready = 1'b0;
    step();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
